// File: rtl/sb_tx_arb_pkg.sv
// Shared types and helpers for the sideband TX message arbiter.
// Holds the arbiter state encoding, the default framer widths and the
// flattened-bus slice extractor used to pick one requester's payload.
package sb_tx_arb_pkg;

   localparam int SB_HDR_W_DEF  = 62;
   localparam int SB_DATA_W_DEF = 64;

   // Widest single slice and widest flattened bus the helper can handle
   // (up to 8 requesters of up to 64 bits each).
   localparam int SLICE_MAX_W = 64;
   localparam int FLAT_MAX_W  = 8 * SLICE_MAX_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT_HDR,
      ST_WAIT_DATA,
      ST_DONE
   } sb_arb_state_e;

   // Return slice idx of width w from a zero-extended flattened bus; the
   // caller truncates the result to its own field width.
   function automatic logic [SLICE_MAX_W-1:0] sb_flat_slice(
      input logic [FLAT_MAX_W-1:0] flat,
      input int                    idx,
      input int                    w
   );
      return SLICE_MAX_W'(flat >> (idx * w));
   endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin selector: finds the first asserted request at
// or above the pointer, wrapping past NUM_REQ-1 back to 0.
module sb_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   idx_o,
   output logic               any_o
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [PTR_W-1:0]     off;
   logic [PTR_W:0]       sum;

   // Rotate so the pointer position lands on bit 0; doubling gives the wrap.
   assign req_dbl = {req_i, req_i};
   assign rot     = NUM_REQ'(req_dbl >> ptr_i);

   // Lowest set bit of the rotated vector, mapped back to an absolute index.
   always_comb begin
      off   = '0;
      any_o = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off   = PTR_W'(k);
            any_o = 1'b1;
         end
      end
      sum = {1'b0, ptr_i} + {1'b0, off};
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
         sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx_o = sum[PTR_W-1:0];
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
         assign gnt_o[gi] = any_o && (idx_o == PTR_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/sb_tx_msg_arbiter.sv
// Sideband TX message arbiter: grants one message source at a time
// (round-robin), loads its header/data into the framer with a one-cycle
// valid pulse and holds them until every packet phase has been emitted.
// Optional watchdog abort is compiled in with `define SB_ARB_WDOG_EN.
module sb_tx_msg_arbiter
   import sb_tx_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HDR_W       = SB_HDR_W_DEF,
   parameter int DATA_W      = SB_DATA_W_DEF,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*HDR_W-1:0]  i_req_header,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]        i_req_has_data,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic [HDR_W-1:0]          o_header,
   output logic [DATA_W-1:0]         o_data,
   output logic                      o_header_valid,
   output logic                      o_d_valid,
   input  logic                      i_packet_valid,
   output logic                      o_busy,
   output logic                      o_err
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sb_arb_state_e      state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   ptr_d;
   logic [HDR_W-1:0]   header_q;
   logic [DATA_W-1:0]  data_q;
   logic               has_data_q;
   logic               valid_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [PTR_W-1:0]   arb_idx;
   logic               arb_any;
   logic [HDR_W-1:0]   sel_header;
   logic [DATA_W-1:0]  sel_data;

   sb_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req_i   (i_req),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   // Data is forced to zero for header-only packets: the framer treats any
   // non-zero data value as "data phase present".
   assign sel_header = HDR_W'(sb_flat_slice(FLAT_MAX_W'(i_req_header), int'(arb_idx), HDR_W));
   assign sel_data   = i_req_has_data[arb_idx]
                     ? DATA_W'(sb_flat_slice(FLAT_MAX_W'(i_req_data), int'(arb_idx), DATA_W))
                     : '0;
   assign ptr_d      = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);

   // Grant is only offered in IDLE, and is held off while reset is asserted.
   assign o_gnt          = (i_rst_n && (state_q == ST_IDLE)) ? arb_gnt : '0;
   assign o_header       = header_q;
   assign o_data         = data_q;
   assign o_header_valid = valid_q;
   assign o_d_valid      = valid_q;
   assign o_busy         = (state_q != ST_IDLE);

`ifdef SB_ARB_WDOG_EN
   localparam int CNT_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

   logic [CNT_W-1:0] wdog_cnt_q;
   logic             err_q;
   logic             in_wait;
   logic             wdog_hit;

   assign in_wait  = (state_q == ST_WAIT_HDR) || (state_q == ST_WAIT_DATA);
   assign wdog_hit = in_wait && !i_packet_valid && (wdog_cnt_q == CNT_W'(WDOG_CYCLES - 1));
   assign o_err    = err_q;

   // Watchdog counts idle cycles in a wait state; any state change clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wdog_cnt_q <= '0;
      end else if (in_wait && !i_packet_valid && !wdog_hit) begin
         wdog_cnt_q <= wdog_cnt_q + CNT_W'(1);
      end else begin
         wdog_cnt_q <= '0;
      end
   end
`else
   assign o_err = 1'b0;
`endif

   // Packet sequencing FSM with registered framer-side outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         header_q   <= '0;
         data_q     <= '0;
         has_data_q <= 1'b0;
         valid_q    <= 1'b0;
`ifdef SB_ARB_WDOG_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arb_any) begin
                  header_q   <= sel_header;
                  data_q     <= sel_data;
                  has_data_q <= i_req_has_data[arb_idx];
                  ptr_q      <= ptr_d;
                  valid_q    <= 1'b1;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               valid_q <= 1'b0;
               state_q <= ST_WAIT_HDR;
            end
            ST_WAIT_HDR: begin
               if (i_packet_valid) begin
                  state_q <= has_data_q ? ST_WAIT_DATA : ST_DONE;
               end
`ifdef SB_ARB_WDOG_EN
               else if (wdog_hit) begin
                  err_q   <= 1'b1;
                  state_q <= ST_DONE;
               end
`endif
            end
            ST_WAIT_DATA: begin
               if (i_packet_valid) begin
                  state_q <= ST_DONE;
               end
`ifdef SB_ARB_WDOG_EN
               else if (wdog_hit) begin
                  err_q   <= 1'b1;
                  state_q <= ST_DONE;
               end
`endif
            end
            ST_DONE: begin
               // Gap cycle lets the framer clear its header-sent flag.
               header_q <= '0;
               data_q   <= '0;
`ifdef SB_ARB_WDOG_EN
               err_q    <= 1'b0;
`endif
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
